// File: rtl/barrido_filas_pkg.sv
`default_nettype none
// ============================================================================
// Module   : barrido_filas_pkg
// Brief    : Shared panel geometry defaults and row-scan FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package barrido_filas_pkg;

    // Panel geometry shared with the enviaDatos and LATSTB stages
    localparam int c_def_row_bits = 4;
    localparam int c_def_n_rows   = 16;

    localparam int c_brillo_w = 8;

    typedef enum logic [2:0] {
        REPOSO   = 3'd0,
        APAGA    = 3'd1,
        CAMBIA   = 3'd2,
        ASENTA   = 3'd3,
        ENCIENDE = 3'd4
    } estado_t;

endpackage : barrido_filas_pkg
`default_nettype wire

// File: rtl/barrido_filas_if.sv
`default_nettype none
// ============================================================================
// Module   : barrido_filas_if
// Brief    : LATSTB-side inputs and panel-side outputs of the row scanner.
// Revision : 1.0 - initial release
// ============================================================================
interface barrido_filas_if
    import barrido_filas_pkg::*;
#(
    parameter int ROW_BITS = c_def_row_bits
);

    logic                  lat;
    logic                  stb;
    logic [c_brillo_w-1:0] brillo;
    logic [ROW_BITS-1:0]   fila;
    logic                  oe_n;
    logic                  inicio_cuadro;
    logic                  overrun;

    modport master (
        output lat,
        output stb,
        output brillo,
        input  fila,
        input  oe_n,
        input  inicio_cuadro,
        input  overrun
    );

    modport slave (
        input  lat,
        input  stb,
        input  brillo,
        output fila,
        output oe_n,
        output inicio_cuadro,
        output overrun
    );

endinterface : barrido_filas_if
`default_nettype wire

// File: rtl/barrido_filas_detecta_flanco.sv
`default_nettype none
// ============================================================================
// Module   : detecta_flanco
// Brief    : Rising-edge detector; the pulse is combinational from the input
//            and the previous-cycle sample, so it lands in the edge cycle.
// Revision : 1.0 - initial release
// ============================================================================
module detecta_flanco (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_d,
    output logic      o_rise
);

    logic r_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_q <= 1'b0;
        end else begin
            r_d_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_d_q;

endmodule : detecta_flanco
`default_nettype wire

// File: rtl/barrido_filas.sv
`default_nettype none
// ============================================================================
// Module   : barrido_filas
// Brief    : Row-scan and output-enable controller: blanks on each latch,
//            steps the row, settles, then unblanks for a brightness on-time.
// Revision : 1.0 - initial release
// ============================================================================
module barrido_filas
    import barrido_filas_pkg::*;
#(
    parameter int ROW_BITS  = c_def_row_bits,
    parameter int N_ROWS    = c_def_n_rows,
    parameter int BLANK_CYC = 4,
    parameter int ON_SHIFT  = 2
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    barrido_filas_if.slave bus
);

    localparam int c_BC_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int c_ON_W = c_brillo_w + ON_SHIFT;

    localparam logic [c_BC_W-1:0]   c_BLANK_LAST = c_BC_W'(BLANK_CYC - 1);
    localparam logic [ROW_BITS-1:0] c_LAST_ROW   = ROW_BITS'(N_ROWS - 1);
    localparam logic [c_ON_W-1:0]   c_ON_ONE     = c_ON_W'(1);

    estado_t             r_state;
    estado_t             w_state_nx;
    logic [c_BC_W-1:0]   r_blank_cnt;
    logic [c_BC_W-1:0]   w_blank_cnt_nx;
    logic [c_ON_W-1:0]   r_on_cnt;
    logic [c_ON_W-1:0]   w_on_cnt_nx;
    logic [c_ON_W-1:0]   w_on_time;
    logic [ROW_BITS-1:0] r_fila;
    logic [ROW_BITS-1:0] w_fila_nx;
    logic [ROW_BITS-1:0] w_fila_inc;
    logic                r_pending;
    logic                w_pending_nx;
    logic                r_overrun;
    logic                w_overrun_nx;
    logic                r_inicio;
    logic                w_inicio_nx;
    logic                r_oe_n;
    logic                w_lat_rise;
    logic                w_in_blank;

    detecta_flanco u_lat_flanco (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (bus.lat),
        .o_rise (w_lat_rise)
    );

    assign w_on_time  = c_ON_W'(bus.brillo) << ON_SHIFT;
    assign w_fila_inc = (r_fila == c_LAST_ROW) ? '0 : r_fila + 1'b1;
    assign w_in_blank = (r_state == APAGA) || (r_state == CAMBIA) || (r_state == ASENTA);

    always_comb begin
        w_state_nx     = r_state;
        w_blank_cnt_nx = r_blank_cnt;
        w_on_cnt_nx    = r_on_cnt;
        w_fila_nx      = r_fila;
        w_pending_nx   = r_pending;
        w_overrun_nx   = r_overrun;
        w_inicio_nx    = 1'b0;

        case (r_state)
            REPOSO: begin
                if (w_lat_rise || r_pending) begin
                    w_state_nx     = APAGA;
                    w_blank_cnt_nx = c_BLANK_LAST;
                    // A fresh edge arriving while a queued one is taken stays queued
                    w_pending_nx   = r_pending & w_lat_rise;
                end
            end
            APAGA: begin
                if (r_blank_cnt == '0) begin
                    w_state_nx = CAMBIA;
                end else begin
                    w_blank_cnt_nx = r_blank_cnt - 1'b1;
                end
            end
            CAMBIA: begin
                w_fila_nx      = w_fila_inc;
                w_inicio_nx    = (w_fila_inc == '0);
                w_blank_cnt_nx = c_BLANK_LAST;
                w_state_nx     = ASENTA;
            end
            ASENTA: begin
                if (r_blank_cnt == '0) begin
                    w_on_cnt_nx = w_on_time;
                    w_state_nx  = (w_on_time == '0) ? REPOSO : ENCIENDE;
                end else begin
                    w_blank_cnt_nx = r_blank_cnt - 1'b1;
                end
            end
            ENCIENDE: begin
                if (w_lat_rise) begin
                    w_state_nx     = APAGA;
                    w_blank_cnt_nx = c_BLANK_LAST;
                    w_on_cnt_nx    = '0;
                end else if (r_on_cnt <= c_ON_ONE) begin
                    w_state_nx  = REPOSO;
                    w_on_cnt_nx = '0;
                end else begin
                    w_on_cnt_nx = r_on_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nx = REPOSO;
            end
        endcase

        // Only one edge can be queued during blanking; any further one is lost
        if (w_lat_rise && w_in_blank) begin
            if (r_pending) begin
                w_overrun_nx = 1'b1;
            end else begin
                w_pending_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= REPOSO;
            r_blank_cnt <= '0;
            r_on_cnt    <= '0;
            r_fila      <= c_LAST_ROW;
            r_pending   <= 1'b0;
            r_overrun   <= 1'b0;
            r_inicio    <= 1'b0;
            r_oe_n      <= 1'b1;
        end else begin
            r_state     <= w_state_nx;
            r_blank_cnt <= w_blank_cnt_nx;
            r_on_cnt    <= w_on_cnt_nx;
            r_fila      <= w_fila_nx;
            r_pending   <= w_pending_nx;
            r_overrun   <= w_overrun_nx;
            r_inicio    <= w_inicio_nx;
            // This flop is the STB sample: in ENCIENDE it holds ~STB of the previous cycle
            r_oe_n      <= ~((w_state_nx == ENCIENDE) & bus.stb);
        end
    end

    assign bus.fila          = r_fila;
    assign bus.oe_n          = r_oe_n;
    assign bus.inicio_cuadro = r_inicio;
    assign bus.overrun       = r_overrun;

endmodule : barrido_filas
`default_nettype wire

// File: doc/barrido_filas.md
Name: barrido_filas

Overview:
- Row-scan and output-enable controller for the LED matrix panel.
- Sits directly downstream of the LATSTB stage and consumes its LAT and STB outputs.
- On every latch event it blanks the panel and advances the row address, then lets the panel settle and unblanks it for a brightness-controlled on-time.
- Drives the panel's row-select and OE_N pins, completing the RX -> enviaDatos -> LATSTB -> barrido_filas chain.

Parameters:
- ROW_BITS, 4: width of the row address.
- N_ROWS, 16: rows scanned. Row wraps N_ROWS-1 -> 0. N_ROWS <= 2**ROW_BITS.
- BLANK_CYC, 4: blanking cycles before and after the row change. Must be >= 1.
- ON_SHIFT, 2: on-time = BRILLO << ON_SHIFT cycles.

Ports:
- CLK, input, 1: system clock. All logic is on the rising edge.
- RST_N, input, 1: asynchronous active-low reset.
- LAT, input, 1: latch pulse from LATSTB. Same clock domain. Only its rising edge is significant.
- STB, input, 1: display gate from LATSTB. Registered once. While the registered value is 0, OE_N is forced to 1.
- BRILLO, input, 8: brightness. Sampled on entry to ENCIENDE.
- FILA, output, ROW_BITS: panel row address.
- OE_N, output, 1: panel output enable, active low. 1 = blanked.
- INICIO_CUADRO, output, 1: one-cycle pulse when FILA becomes 0.
- OVERRUN, output, 1: sticky error flag.

Behaviour:
- Reset (asynchronous, RST_N=0) sets:
  - state = REPOSO
  - FILA = N_ROWS-1, so the first latch selects row 0
  - OE_N = 1, INICIO_CUADRO = 0, OVERRUN = 0
  - pending = 0, LAT_q = 0, STB_q = 0, all counters = 0
- Reset mid-operation aborts immediately. The panel is blanked at once.
- Edge detect: lat_rise = LAT & ~LAT_q, where LAT_q is registered each cycle.
- State machine:
  - REPOSO: OE_N=1. If lat_rise or pending: clear pending, go to APAGA (counter = BLANK_CYC-1).
  - APAGA: OE_N=1. Hold for BLANK_CYC cycles, then go to CAMBIA.
  - CAMBIA: one cycle. FILA <= (FILA==N_ROWS-1) ? 0 : FILA+1, registered and visible the next cycle. If the new value is 0, INICIO_CUADRO=1 for that next cycle only. Go to ASENTA.
  - ASENTA: OE_N=1. Hold for BLANK_CYC cycles. On exit, capture on_cnt = BRILLO << ON_SHIFT (width 8+ON_SHIFT). If on_cnt==0, go to REPOSO, never unblanking. Otherwise go to ENCIENDE.
  - ENCIENDE: OE_N = ~STB_q. Decrement on_cnt. After exactly on_cnt cycles, go to REPOSO.
- lat_rise during ENCIENDE: terminate on-time early. Next cycle go to APAGA, OE_N=1.
- lat_rise during APAGA, CAMBIA or ASENTA:
  - pending=0: set pending=1. It is serviced on the next REPOSO cycle, i.e. REPOSO lasts 1 cycle and then goes to APAGA.
  - pending=1: set OVERRUN=1. OVERRUN clears only on reset. The extra edge is dropped.
- Latency: lat_rise sampled at cycle t gives:
  - OE_N=1 from t+1
  - APAGA t+1..t+BLANK_CYC
  - CAMBIA t+BLANK_CYC+1
  - new FILA from t+BLANK_CYC+2
  - ENCIENDE from t+2*BLANK_CYC+2
- OE_N and FILA are registered outputs with no glitches. OE_N never goes low in the same cycle FILA changes, nor within BLANK_CYC cycles of the change.
- An edge of LAT held high for many cycles counts once.

Decomposition:
- Shared package constants:
  - state encoding (REPOSO, APAGA, CAMBIA, ASENTA, ENCIENDE)
  - default panel geometry (N_ROWS, ROW_BITS), shared with enviaDatos/LATSTB
- One natural sub-module: detecta_flanco, a registered rising-edge detector with asynchronous active-low reset. It is reusable for the LAT and STB inputs elsewhere in the panel path.
- Counters and FSM stay in barrido_filas.

Test Plan:
- Reset check: assert RST_N=0 mid-ENCIENDE -> OE_N=1 and FILA=15 within the same cycle (asynchronous). After release, no activity until LAT rises.
- Basic row step: BLANK_CYC=4, ON_SHIFT=2, BRILLO=3, STB=1; one LAT rise sampled at t -> FILA 15->0 visible at t+6, INICIO_CUADRO=1 only at t+6, OE_N=0 exactly for cycles t+10..t+21 (12 cycles), then 1.
- Frame wrap: 16 spaced LAT pulses -> FILA sequence 0,1,...,15. The 17th pulse gives FILA=0 with a second INICIO_CUADRO pulse, and INICIO_CUADRO fires nowhere else.
- Early termination: BRILLO=255, LAT rise 10 cycles into ENCIENDE -> OE_N=1 the next cycle and FILA advances by exactly 1.
- Zero brightness: BRILLO=0 -> OE_N stays 1 throughout. With STB=0 and BRILLO=3, OE_N also stays 1 while the FSM timing is unchanged.
- Pending and overrun: two LAT rises during APAGA -> second edge serviced after REPOSO (FILA +2 in total), OVERRUN=0. Three rises -> OVERRUN=1 and stays 1 until RST_N.
